// File: rtl/q5_17_2s_comp_pkg.sv
// Shared types and defaults for the serial two's complement blocks
// (transmit complementer and receive deserializer).
package q5_17_2s_comp_pkg;

  // Default word width for the serial complementer family.
  localparam int DESER_W_DEF = 8;

  // Receive-side framing state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;

endpackage

// File: rtl/q5_17_serial_2s_step.sv
// One-bit Mealy two's complementer stage: passes bits unchanged up to and
// including the first 1, inverts every bit after it. Same algorithm as the
// transmit side, so feeding it a complemented stream recovers the operand.
module q5_17_serial_2s_step (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic seen_q, seen_d, seen_eff;

  // A clear arriving with a bit makes that bit the new LSB, so it must see a
  // fresh (zero) seen_one flag in the same cycle.
  assign seen_eff = seen_q & ~clr;
  assign dout     = din ^ seen_eff;

  // Next value of the "a 1 has already gone by" flag.
  always_comb begin
    seen_d = seen_q;
    if (clr) seen_d = 1'b0;
    if (en)  seen_d = seen_eff | din;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (!rst_b) seen_q <= 1'b0;
    else        seen_q <= seen_d;
  end

endmodule

// File: rtl/q5_17_serial_deser.sv
// Serial-to-parallel receiver for the LSB-first two's complement stream.
// Bits shift in at the MSB so the W-th bit leaves bit0 at word_out[0].
// Optional feature: define Q5_17_SERIAL_DECODE_EN to undo the complement
// inline so word_out equals the original operand.
module q5_17_serial_deser
  import q5_17_2s_comp_pkg::*;
#(
  parameter int W     = DESER_W_DEF,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             stream,
  input  logic             bit_valid,
  input  logic             sop,
  output logic [W-1:0]     word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  deser_state_t     state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             take_bit, take_sop;
  logic             bit_in;

`ifdef Q5_17_SERIAL_DECODE_EN
  // seen_one restarts on every accepted sop, aborts included.
  q5_17_serial_2s_step u_step (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (take_sop),
    .en    (take_bit),
    .din   (stream),
    .dout  (bit_in)
  );
`else
  assign bit_in = stream;
`endif

  // Framing FSM: decides which bits are captured and updates counters/flags.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    ovr_d    = ovr_q;
    ferr_d   = 1'b0;
    take_bit = 1'b0;
    take_sop = 1'b0;
    case (state_q)
      IDLE: begin
        // Bits outside a frame are silently ignored.
        if (bit_valid && sop) begin
          take_bit = 1'b1;
          take_sop = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          take_bit = 1'b1;
          if (sop) begin
            // Restart: the older partial bits shift out before the word fills.
            take_sop = 1'b1;
            ferr_d   = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == CNT_W'(W - 1)) begin
            cnt_d   = CNT_W'(W);
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
          // Zero-bubble: a sop in the handshake cycle opens the next frame.
          if (bit_valid && sop) begin
            take_bit = 1'b1;
            take_sop = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end
        end else if (bit_valid) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_bit) sr_d = {bit_in, sr_q[W-1:1]};
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign word_out   = sr_q;
  assign word_valid = vld_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_q5_17_serial_deser.sv
// Self-checking bench for q5_17_serial_deser (W=8). A frame-level model
// (bit list -> integer word, negated when Q5_17_SERIAL_DECODE_EN is set)
// is checked every cycle, plus directed frames with literal expectations.
module tb_q5_17_serial_deser;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 1);
`ifdef Q5_17_SERIAL_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             stream = 1'b0;
  logic             bit_valid = 1'b0;
  logic             sop = 1'b0;
  logic             word_ready = 1'b0;
  logic [W-1:0]     word_out;
  logic             word_valid;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             frame_err;

  int errs   = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state
  bit           frame[W];
  int           m_n    = 0;
  bit           m_held = 1'b0;
  bit           m_ovr  = 1'b0;
  bit           m_ferr = 1'b0;
  logic [W-1:0] m_word = '0;

  q5_17_serial_deser #(.W(W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .stream     (stream),
    .bit_valid  (bit_valid),
    .sop        (sop),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word value of the collected frame; decoding is arithmetic negation.
  function automatic logic [W-1:0] frame_word();
    logic [W-1:0] raw;
    raw = '0;
    for (int i = 0; i < W; i++) raw[i] = frame[i];
    return DEC ? -raw : raw;
  endfunction

  // Frame-level reference, evaluated on each rising edge with the inputs seen there.
  task automatic model_update();
    if (!rst_b) begin
      m_n = 0; m_held = 0; m_ovr = 0; m_ferr = 0; m_word = '0;
    end else begin
      m_ferr = 0;
      if (m_held) begin
        if (word_ready) begin
          m_held = 0;
          m_n    = 0;
          if (bit_valid && sop) begin frame[0] = stream; m_n = 1; end
        end else if (bit_valid) begin
          m_ovr = 1;
        end
      end else if (bit_valid) begin
        if (sop) begin
          if (m_n > 0) m_ferr = 1;
          frame[0] = stream;
          m_n      = 1;
        end else if (m_n > 0) begin
          frame[m_n] = stream;
          m_n++;
        end
        if (m_n == W) begin
          m_held = 1;
          m_word = frame_word();
        end
      end
    end
  endtask

  task automatic step(input logic rb, input logic bv, input logic sp,
                      input logic st, input logic rdy);
    rst_b = rb; bit_valid = bv; sop = sp; stream = st; word_ready = rdy;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Sends one full frame LSB first with sop on bit0; checks assembly progress.
  task automatic send_frame(input logic [W-1:0] bits, input logic rdy,
                            input logic exp_ferr, input string nm);
    for (int i = 0; i < W; i++) begin
      step(1'b1, 1'b1, (i == 0), bits[i], rdy);
      if (i < W - 1) begin
        chk({nm, ".valid_lo"}, word_valid, 0);
        chk({nm, ".cnt"}, bit_cnt, i + 1);
      end
      if (i == 0) chk({nm, ".ferr0"}, frame_err, exp_ferr);
      if (i == 1) chk({nm, ".ferr1"}, frame_err, 0);
    end
    chk({nm, ".valid"}, word_valid, 1);
    chk({nm, ".cnt_full"}, bit_cnt, W);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m.word_valid", word_valid, m_held);
      chk("m.bit_cnt", bit_cnt, m_n);
      chk("m.overrun", overrun, m_ovr);
      chk("m.frame_err", frame_err, m_ferr);
      if (m_held) chk("m.word_out", word_out, m_word);
    end
  end

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_on = 1'b1;
    chk("rst.valid", word_valid, 0);
    chk("rst.cnt", bit_cnt, 0);
    chk("rst.ovr", overrun, 0);
    chk("rst.ferr", frame_err, 0);
    chk("rst.word", word_out, 0);
    step(1, 0, 0, 0, 0);
    chk("post_rst.valid", word_valid, 0);
    // Stray bit outside a frame is ignored
    step(1, 1, 0, 1, 0);
    chk("stray.cnt", bit_cnt, 0);

    // Reset mid-frame
    step(1, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    chk("midrst.cnt_pre", bit_cnt, 4);
    step(0, 0, 0, 0, 0);
    chk("midrst.cnt", bit_cnt, 0);
    chk("midrst.valid", word_valid, 0);

    // 1,1,0,1,1,1,1,1 -> 0xFB raw / 0x05 decoded, valid for one cycle
    send_frame(8'hFB, 1, 0, "fb");
    chk("fb.word", word_out, DEC ? 8'h05 : 8'hFB);
    step(1, 0, 0, 0, 1);
    chk("fb.valid_1cyc", word_valid, 0);

    // Edge operands
    send_frame(8'h80, 1, 0, "x80");
    chk("x80.word", word_out, 8'h80);
    step(1, 0, 0, 0, 1);
    send_frame(8'h00, 1, 0, "zero");
    chk("zero.word", word_out, 8'h00);
    step(1, 0, 0, 0, 1);

    // Back-to-back: second sop lands in the handshake cycle
    send_frame(8'hA5, 1, 0, "b2b1");
    chk("b2b1.word", word_out, DEC ? 8'h5B : 8'hA5);
    send_frame(8'h3C, 1, 0, "b2b2");
    chk("b2b2.word", word_out, DEC ? 8'hC4 : 8'h3C);
    chk("b2b2.ovr", overrun, 0);
    step(1, 0, 0, 0, 1);

    // Backpressure
    send_frame(8'h69, 0, 0, "bp");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1'($urandom), 0);
    chk("bp.word", word_out, DEC ? 8'h97 : 8'h69);
    chk("bp.valid", word_valid, 1);
    chk("bp.ovr", overrun, 1);
    step(1, 0, 0, 0, 1);
    chk("bp.valid_drop", word_valid, 0);
    chk("bp.ovr_sticky", overrun, 1);
    step(1, 0, 0, 0, 0);
    chk("bp.ovr_sticky2", overrun, 1);
    step(0, 0, 0, 0, 0);
    chk("bp.ovr_rst", overrun, 0);

    // Abort: sop + 3 bits, then a new sop restarts the frame
    step(1, 1, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    send_frame(8'h96, 1, 1, "abort");
    chk("abort.word", word_out, DEC ? 8'h6A : 8'h96);
    step(1, 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) < 2),
           1'($urandom),
           ($urandom_range(0, 9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/q5_17_serial_deser.md
Name: q5_17_serial_deser

Overview:
- Receive-side companion to the serial 2's complementer.
- Collects the LSB-first serial bit stream (one bit per accepted cycle) back into a parallel word, framed by a start-of-frame strobe.
- Presents the word on a valid/ready output handshake.
- Optionally undoes the two's complement serially so the recovered word equals the original operand; used by benches and downstream parallel logic.

Parameters:
- W, 8, word width in bits (>= 2).
- CNT_W, $clog2(W+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  synchronous active-low reset
- stream  input  1  serial data bit, LSB first
- bit_valid  input  1  stream is sampled this cycle when high
- sop  input  1  start of frame; only meaningful with bit_valid; marks the LSB
- word_out  output  W  assembled word
- word_valid  output  1  word_out holds a complete frame
- word_ready  input  1  consumer accepts word_out
- bit_cnt  output  CNT_W  bits captured in the current frame
- overrun  output  1  sticky: bit dropped while a word was held
- frame_err  output  1  one-cycle pulse: sop arrived mid-frame

Behaviour:
- Reset (rst_b=0 at a clk edge):
  - state=IDLE; word_out=0; word_valid=0; bit_cnt=0; overrun=0; frame_err=0; decode flag cleared.
  - Reset mid-frame discards partial data. No output is asserted in the reset cycle or in the cycle after it.
- State IDLE:
  - bit_valid & sop: write bit to shift register MSB (shift right), bit_cnt=1, go SHIFT.
  - bit_valid & !sop: bit ignored, no flag.
- State SHIFT (bit_valid):
  - Shift right, new bit into MSB, bit_cnt++.
  - When bit_cnt reaches W: go HOLD, word_valid=1 next cycle, bit_cnt=W. LSB-first arrival therefore lands bit0 at word_out[0].
  - No bit_valid: hold everything; gaps are allowed.
  - sop with bit_valid mid-frame: abort the partial frame, restart with this bit as bit0 (bit_cnt=1), pulse frame_err for one cycle.
- State HOLD:
  - word_out stable while word_valid=1 and word_ready=0.
  - word_valid & word_ready: clear word_valid next cycle, go IDLE.
  - Same cycle also bit_valid & sop: start the new frame directly (go SHIFT, bit_cnt=1). Zero-bubble back-to-back.
  - bit_valid without the ready handshake completing: bit dropped, overrun=1 (sticky until reset).
- Latency: word_valid rises on the edge that samples the W-th bit, i.e. visible in the cycle after that bit is presented.
- W=8 frame: sop on cycle 0 gives word_valid from cycle 8 at full rate.
- No arithmetic beyond the counter. bit_cnt saturates at W and never wraps.

Optional Feature:
- Macro: Q5_17_SERIAL_DECODE_EN
- Defined:
  - Incoming bits pass through an inline serial two's complementer before the shift register.
  - out = stream XOR seen_one, then seen_one |= stream.
  - seen_one clears on every accepted sop (including an abort) and on reset.
  - word_out equals the original operand fed to the transmitting complementer.
- Undefined:
  - Raw bits are stored; word_out is the complemented value.
  - seen_one logic is absent.

Decomposition:
- Add to q5_17_2s_comp_pkg:
  - enum deser_state_t {IDLE, SHIFT, HOLD}.
  - Default width constant (W default).
- Sub-module q5_17_serial_2s_step: one-bit Mealy complementer stage with ports clk, rst_b, clr, en, din, dout. It is instantiated only under Q5_17_SERIAL_DECODE_EN and shares the algorithm with the transmit side.

Test Plan (W=8):
- Reset mid-frame: sop + 3 bits, then rst_b=0 for 1 cycle -> bit_cnt=0, word_valid=0, next sop frame assembles cleanly.
- Stream 1,1,0,1,1,1,1,1 (sop on first bit), word_ready=1 -> word_out=0xFB without the macro, 0x05 with Q5_17_SERIAL_DECODE_EN; word_valid one cycle.
- Edge values:
  - Operand 0x80 (stream 0,0,0,0,0,0,0,1) -> 0x80 in both builds.
  - All-zero stream -> 0x00 in both builds.
- Back-to-back: word_ready=1 and a new sop in the HOLD-exit cycle -> second word valid exactly 8 cycles after the first, no overrun.
- Backpressure: word_ready=0, 3 more bit_valid -> word_out unchanged, overrun=1 and stays 1 after the later ready.
- Abort: sop, 4 bits, then sop again -> frame_err pulse 1 cycle, bit_cnt=1, next word built only from the second frame.
